// File: rtl/axi_slave_mem.sv
// AXI3-style burst slave backed by a word-wide synchronous memory.
// Write and read channels are served by independent FSMs sharing one array.
module axi_slave_mem #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024
) (
    input  logic                aclk,
    input  logic                arst,
    input  logic [ID_W-1:0]     awid,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [3:0]          awlen,
    input  logic [1:0]          awburst,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    input  logic                wvalid,
    output logic                wready,
    output logic [ID_W-1:0]     bid,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    input  logic [ID_W-1:0]     arid,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic [3:0]          arlen,
    input  logic [1:0]          arburst,
    input  logic                arvalid,
    output logic                arready,
    output logic [ID_W-1:0]     rid,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rlast,
    output logic                rvalid,
    input  logic                rready
);

    localparam int BYTES = DATA_W / 8;
    localparam int LSB   = $clog2(BYTES);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(BYTES);
    localparam logic [ADDR_W-1:0] LIMIT      = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(STEP - ADDR_W'(1));
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    function automatic logic [ADDR_W-1:0] next_addr(
        input logic [ADDR_W-1:0] a,
        input logic [3:0]        len,
        input logic [1:0]        burst
    );
        logic [ADDR_W-1:0] mask;
        logic [ADDR_W-1:0] nxt;
        logic              wrap_ok;
        // Wrap window spans (len+1) beats, aligned to its own size.
        mask    = (ADDR_W'({1'b0, len} + 5'd1) << LSB) - ADDR_W'(1);
        wrap_ok = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
        case (burst)
            2'b00:   nxt = a;
            2'b10:   nxt = wrap_ok ? ((a & ~mask) | ((a + STEP) & mask)) : (a + STEP);
            default: nxt = a + STEP;
        endcase
        return nxt;
    endfunction

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return (a >> LSB) < LIMIT;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'(a >> LSB);
    endfunction

    // ---------------- write channel ----------------
    w_state_t          w_state;
    logic [ID_W-1:0]   w_id;
    logic [ADDR_W-1:0] w_addr;
    logic [3:0]        w_len;
    logic [1:0]        w_burst;
    logic [3:0]        w_beat;
    logic              w_err;
    logic              w_fire;
    logic              w_hit;
    logic              w_beat_bad;

    always_comb begin
        w_fire     = (w_state == W_DATA) && wvalid && wready;
        w_hit      = in_range(w_addr);
        w_beat_bad = !w_hit || (wlast != (w_beat == w_len));
    end

    always_ff @(posedge aclk) begin
        if (arst) begin
            w_state <= W_IDLE;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bid     <= '0;
            bresp   <= '0;
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_burst <= '0;
            w_beat  <= '0;
            w_err   <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (awvalid && awready) begin
                        w_id    <= awid;
                        w_addr  <= awaddr & ALIGN_MASK;
                        w_len   <= awlen;
                        w_burst <= awburst;
                        w_beat  <= '0;
                        w_err   <= 1'b0;
                        awready <= 1'b0;
                        wready  <= 1'b1;
                        w_state <= W_DATA;
                    end else begin
                        awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        w_addr <= next_addr(w_addr, w_len, w_burst);
                        // Beat count, not wlast, terminates the burst.
                        if (w_beat == w_len) begin
                            wready  <= 1'b0;
                            bvalid  <= 1'b1;
                            bid     <= w_id;
                            bresp   <= (w_err || w_beat_bad) ? RESP_SLVERR : RESP_OKAY;
                            w_state <= W_RESP;
                        end else begin
                            w_beat <= w_beat + 4'd1;
                            w_err  <= w_err || w_beat_bad;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (!arst && w_fire && w_hit) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
                if (wstrb[b]) begin
                    mem[word_idx(w_addr)][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // ---------------- read channel ----------------
    r_state_t          r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_len;
    logic [1:0]        r_burst;
    logic [3:0]        r_beat;
    logic [ADDR_W-1:0] r_src;
    logic              r_src_hit;
    logic [DATA_W-1:0] r_word;

    // Address of the beat to fetch at the coming edge; memory is read before
    // any same-edge write lands, so a colliding read sees the old word.
    always_comb begin
        r_src     = (r_state == R_IDLE) ? (araddr & ALIGN_MASK)
                                        : next_addr(r_addr, r_len, r_burst);
        r_src_hit = in_range(r_src);
        r_word    = mem[word_idx(r_src)];
    end

    always_ff @(posedge aclk) begin
        if (arst) begin
            r_state <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rid     <= '0;
            rdata   <= '0;
            rresp   <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_burst <= '0;
            r_beat  <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (arvalid && arready) begin
                        r_addr  <= r_src;
                        r_len   <= arlen;
                        r_burst <= arburst;
                        r_beat  <= '0;
                        rid     <= arid;
                        arready <= 1'b0;
                        rvalid  <= 1'b1;
                        rlast   <= (arlen == 4'd0);
                        rdata   <= r_src_hit ? r_word : '0;
                        rresp   <= r_src_hit ? RESP_OKAY : RESP_SLVERR;
                        r_state <= R_DATA;
                    end else begin
                        arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        if (rlast) begin
                            rvalid  <= 1'b0;
                            rlast   <= 1'b0;
                            arready <= 1'b1;
                            r_state <= R_IDLE;
                        end else begin
                            r_addr <= r_src;
                            r_beat <= r_beat + 4'd1;
                            rlast  <= ((r_beat + 4'd1) == r_len);
                            rdata  <= r_src_hit ? r_word : '0;
                            rresp  <= r_src_hit ? RESP_OKAY : RESP_SLVERR;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_slave_mem.sv
// Scoreboard bench for axi_slave_mem: drivers push expected B/R responses from
// a flat reference memory; a negedge monitor pops and compares on handshakes.
module tb_axi_slave_mem;

    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 64;

    logic              aclk = 1'b0;
    logic              arst;
    logic [ID_W-1:0]   awid, arid, bid, rid;
    logic [ADDR_W-1:0] awaddr, araddr;
    logic [3:0]        awlen, arlen;
    logic [1:0]        awburst, arburst, bresp, rresp;
    logic              awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic              arvalid, arready, rlast, rvalid, rready;
    logic [DATA_W-1:0] wdata, rdata;
    logic [3:0]        wstrb;

    always #5 aclk = ~aclk;

    axi_slave_mem #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .aclk(aclk), .arst(arst),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    typedef struct { logic [3:0] id; logic [1:0] resp; } b_t;
    typedef struct { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_t;

    b_t          b_exp[$];
    r_t          r_exp[$];
    b_t          b_cur;
    r_t          r_cur;
    logic [31:0] mdl [DEPTH];
    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic        wl [16];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Byte address of beat i, straight from the burst definitions.
    function automatic logic [31:0] beat_addr(input logic [31:0] start, input logic [3:0] len,
                                              input logic [1:0] burst, input int i);
        logic [31:0] a, span, base, off;
        a   = start & ~32'd3;
        off = 32'(i) * 32'd4;
        if (burst == 2'b00) return a;
        if (burst == 2'b10 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
            span = (32'(len) + 32'd1) * 32'd4;
            base = a - (a % span);
            return base + ((a - base + off) % span);
        end
        return a + off;
    endfunction

    always @(negedge aclk) begin
        if (!arst && bvalid && bready) begin
            if (b_exp.size() == 0) chk("b_unexpected", 64'd1, 64'd0);
            else begin
                b_cur = b_exp.pop_front();
                chk("bid", 64'(bid), 64'(b_cur.id));
                chk("bresp", 64'(bresp), 64'(b_cur.resp));
            end
        end
        if (!arst && rvalid && rready) begin
            if (r_exp.size() == 0) chk("r_unexpected", 64'd1, 64'd0);
            else begin
                r_cur = r_exp.pop_front();
                chk("rid", 64'(rid), 64'(r_cur.id));
                chk("rdata", 64'(rdata), 64'(r_cur.data));
                chk("rresp", 64'(rresp), 64'(r_cur.resp));
                chk("rlast", 64'(rlast), 64'(r_cur.last));
            end
        end
    end

    task automatic fill_beats(input logic [3:0] len, input bit rand_strb);
        for (int i = 0; i < 16; i++) begin
            wd[i] = $urandom;
            ws[i] = rand_strb ? 4'($urandom_range(0, 15)) : 4'hF;
            wl[i] = (i == int'(len));
        end
    endtask

    task automatic push_read_exp(input logic [3:0] id, input logic [31:0] addr,
                                 input logic [3:0] len, input logic [1:0] burst);
        logic [31:0] a;
        for (int i = 0; i <= int'(len); i++) begin
            a = beat_addr(addr, len, burst, i);
            if (a >= 32'(DEPTH * 4)) r_exp.push_back('{id, 32'd0, 2'b10, i == int'(len)});
            else                     r_exp.push_back('{id, mdl[a >> 2], 2'b00, i == int'(len)});
        end
    endtask

    task automatic write_burst(input logic [3:0] id, input logic [31:0] addr,
                               input logic [3:0] len, input logic [1:0] burst);
        logic        err;
        logic [31:0] a;
        int          n;
        err = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            a = beat_addr(addr, len, burst, i);
            if (a >= 32'(DEPTH * 4)) err = 1'b1;
            else for (int b = 0; b < 4; b++) if (ws[i][b]) mdl[a >> 2][8*b +: 8] = wd[i][8*b +: 8];
            if (wl[i] != (i == int'(len))) err = 1'b1;
        end
        b_exp.push_back('{id, err ? 2'b10 : 2'b00});
        awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 50) begin @(negedge aclk); n++; end
        if (!awready) chk("aw_timeout", 64'd0, 64'd1);
        @(posedge aclk); #1 awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wdata = wd[i]; wstrb = ws[i]; wlast = wl[i]; wvalid = 1'b1;
            if (i > 0) chk("w_ready_back_to_back", 64'(wready), 64'd1);
            n = 0;
            while (!wready && n < 50) begin @(negedge aclk); n++; end
            if (!wready) chk("w_timeout", 64'd0, 64'd1);
            @(posedge aclk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        n = 0;
        while (!bvalid && n < 50) begin @(negedge aclk); n++; end
        if (!bvalid) chk("b_timeout", 64'd0, 64'd1);
        @(posedge aclk); #1;
        chk("aw_idle_after_b", 64'({bvalid, awready}), 64'b01);
    endtask

    task automatic read_burst(input logic [3:0] id, input logic [31:0] addr,
                              input logic [3:0] len, input logic [1:0] burst, input int stall);
        logic [39:0] snap;
        int          n;
        push_read_exp(id, addr, len, burst);
        arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
        rready = (stall != 0);
        n = 0;
        while (!arready && n < 50) begin @(negedge aclk); n++; end
        if (!arready) chk("ar_timeout", 64'd0, 64'd1);
        @(posedge aclk); #1 arvalid = 1'b0;
        chk("r_first_beat_latency", 64'(rvalid), 64'd1);
        for (int i = 0; i <= int'(len); i++) begin
            if (i == stall) begin
                rready = 1'b0;
                snap = {rid, rdata, rresp, rlast, rvalid};
                repeat (3) begin
                    @(posedge aclk); #1;
                    chk("r_stall_hold", 64'({rid, rdata, rresp, rlast, rvalid}), 64'(snap));
                end
                rready = 1'b1;
            end else if (i > 0) begin
                chk("r_back_to_back", 64'(rvalid), 64'd1);
            end
            n = 0;
            while (!rvalid && n < 50) begin @(negedge aclk); n++; end
            if (!rvalid) chk("r_timeout", 64'd0, 64'd1);
            @(posedge aclk); #1;
        end
        chk("r_idle_after_last", 64'({rvalid, arready}), 64'b01);
        rready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  len;
        logic [1:0]  burst;
        logic [31:0] addr;
        int          n;
        arst = 1'b1;
        awid = '0; awaddr = '0; awlen = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b1;
        arid = '0; araddr = '0; arlen = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_ready_valid", 64'({awready, wready, bvalid, arready, rvalid, rlast}), 64'd0);
        chk("rst_b_fields", 64'({bid, bresp}), 64'd0);
        chk("rst_r_fields", 64'({rid, rdata, rresp}), 64'd0);
        arst = 1'b0;
        @(posedge aclk); #1;
        chk("rst_release_ready", 64'({awready, arready}), 64'b11);

        for (int k = 0; k < DEPTH / 16; k++) begin
            fill_beats(4'd15, 1'b0);
            write_burst(4'(k), 32'(k * 64), 4'd15, 2'b01);
        end

        // INCR write/read of four words
        fill_beats(4'd3, 1'b0);
        for (int i = 0; i < 4; i++) wd[i] = 32'hA0 + 32'(i);
        write_burst(4'd5, 32'h10, 4'd3, 2'b01);
        read_burst(4'd6, 32'h10, 4'd3, 2'b01, -1);

        // WRAP write from 0x08, then FIXED re-reads of 0x04
        fill_beats(4'd3, 1'b0);
        for (int i = 0; i < 4; i++) wd[i] = 32'hA0 + 32'(i);
        write_burst(4'd7, 32'h08, 4'd3, 2'b10);
        read_burst(4'd8, 32'h04, 4'd2, 2'b00, -1);
        read_burst(4'd9, 32'h00, 4'd3, 2'b01, -1);

        // partial strobes
        fill_beats(4'd0, 1'b0);
        wd[0] = 32'hFFFF_FFFF;
        write_burst(4'd1, 32'h40, 4'd0, 2'b01);
        wd[0] = 32'h1122_3344; ws[0] = 4'b0101;
        write_burst(4'd2, 32'h40, 4'd0, 2'b01);
        read_burst(4'd3, 32'h40, 4'd0, 2'b01, -1);

        // end-of-memory boundary: second beat is out of range
        read_burst(4'd4, 32'((DEPTH - 1) * 4), 4'd1, 2'b01, -1);
        fill_beats(4'd1, 1'b0);
        write_burst(4'd10, 32'((DEPTH - 1) * 4), 4'd1, 2'b01);
        read_burst(4'd11, 32'h0, 4'd0, 2'b01, -1);
        read_burst(4'd12, 32'((DEPTH - 1) * 4), 4'd0, 2'b01, -1);

        // R back-pressure mid-burst, then early wlast
        read_burst(4'd13, 32'h10, 4'd3, 2'b01, 2);
        fill_beats(4'd3, 1'b0);
        wl[1] = 1'b1; wl[3] = 1'b0;
        write_burst(4'd14, 32'h20, 4'd3, 2'b01);
        read_burst(4'd15, 32'h20, 4'd3, 2'b01, -1);

        // reset while beat 2 of a 4-beat read is on the bus
        push_read_exp(4'd6, 32'h30, 4'd3, 2'b01);
        arid = 4'd6; araddr = 32'h30; arlen = 4'd3; arburst = 2'b01; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        while (!arready && n < 50) begin @(negedge aclk); n++; end
        @(posedge aclk); #1 arvalid = 1'b0;
        repeat (2) begin
            n = 0;
            while (!rvalid && n < 50) begin @(negedge aclk); n++; end
            @(posedge aclk); #1;
        end
        arst = 1'b1; rready = 1'b0;
        @(posedge aclk); #1;
        chk("rst_mid_read_rvalid", 64'({rvalid, arready}), 64'b00);
        r_exp.delete();
        arst = 1'b0;
        @(posedge aclk); #1;
        chk("rst_mid_read_ready", 64'({awready, arready}), 64'b11);

        // randomized mix
        for (int t = 0; t < 60; t++) begin
            len   = 4'($urandom_range(0, 15));
            burst = 2'($urandom_range(0, 3));
            addr  = 32'($urandom_range(0, (DEPTH + 6) * 4 - 1));
            if ($urandom_range(0, 1) == 1) begin
                fill_beats(len, 1'b1);
                if ($urandom_range(0, 7) == 0) wl[$urandom_range(0, 15)] ^= 1'b1;
                write_burst(4'($urandom), addr, len, burst);
            end else begin
                read_burst(4'($urandom), addr, len, burst,
                           ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 32'(len))) : -1);
            end
        end

        for (int k = 0; k < DEPTH / 16; k++) read_burst(4'(k), 32'(k * 64), 4'd15, 2'b01, -1);
        repeat (2) @(posedge aclk);
        chk("b_queue_drained", 64'(b_exp.size()), 64'd0);
        chk("r_queue_drained", 64'(r_exp.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_slave_mem.md
AXI_SLAVE_MEM -- requirements
Module: axi_slave_mem

Interface
REQ-001 SHALL have parameter ID_W, default 4, width of all ID fields.
REQ-002 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-003 SHALL have parameter DATA_W, default 32, data width; legal values 32, 64, 128.
REQ-004 SHALL have parameter DEPTH, default 1024, memory size in DATA_W words.
REQ-005 SHALL have port aclk  in  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port arst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port awid  in  ID_W  write transaction ID.
REQ-008 SHALL have port awaddr  in  ADDR_W  write start byte address.
REQ-009 SHALL have port awlen  in  4  write beats minus one.
REQ-010 SHALL have port awburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 treated as INCR.
REQ-011 SHALL have port awvalid  in  1  write address valid.
REQ-012 SHALL have port awready  out  1  write address ready.
REQ-013 SHALL have port wdata  in  DATA_W  write data.
REQ-014 SHALL have port wstrb  in  DATA_W/8  byte enables.
REQ-015 SHALL have port wlast  in  1  final write beat marker.
REQ-016 SHALL have port wvalid  in  1  write data valid.
REQ-017 SHALL have port wready  out  1  write data ready.
REQ-018 SHALL have port bid  out  ID_W  response ID.
REQ-019 SHALL have port bresp  out  2  00 OKAY, 10 SLVERR.
REQ-020 SHALL have port bvalid  out  1  response valid.
REQ-021 SHALL have port bready  in  1  response ready.
REQ-022 SHALL have port arid  in  ID_W  read transaction ID.
REQ-023 SHALL have port araddr  in  ADDR_W  read start byte address.
REQ-024 SHALL have port arlen  in  4  read beats minus one.
REQ-025 SHALL have port arburst  in  2  encoding as awburst.
REQ-026 SHALL have port arvalid  in  1  read address valid.
REQ-027 SHALL have port arready  out  1  read address ready.
REQ-028 SHALL have port rid  out  ID_W  read data ID.
REQ-029 SHALL have port rdata  out  DATA_W  read data.
REQ-030 SHALL have port rresp  out  2  00 OKAY, 10 SLVERR.
REQ-031 SHALL have port rlast  out  1  final read beat marker.
REQ-032 SHALL have port rvalid  out  1  read data valid.
REQ-033 SHALL have port rready  in  1  read data ready.

Function
REQ-034 SHALL run write and read FSMs independently. Transfers are always full DATA_W. Address low log2(DATA_W/8) bits are ignored (address aligned down).
REQ-035 Write FSM SHALL have states W_IDLE (awready=1) -> W_DATA (wready=1) -> W_RESP (bvalid=1) -> W_IDLE. It captures awid/awaddr/awlen/awburst on the AW handshake.
REQ-036 Each W handshake SHALL write the wstrb-enabled bytes to the current word and then advance the address. FIXED holds the address; INCR adds DATA_W/8; WRAP wraps within a (len+1)*DATA_W/8 aligned window. WRAP with len not in {1,3,7,15} is treated as INCR.
REQ-037 W_DATA SHALL exit after beat count == awlen, regardless of wlast. A wlast value mismatching the beat count SHALL force bresp=SLVERR.
REQ-038 A beat whose word index >= DEPTH SHALL be suppressed (memory unchanged) and SHALL force bresp=SLVERR. bid SHALL equal the captured awid.
REQ-039 bvalid, bid and bresp SHALL hold until bready. W_IDLE (awready=1) SHALL be entered the cycle after the B handshake.
REQ-040 Read FSM SHALL have states R_IDLE (arready=1) -> R_DATA -> R_IDLE. rvalid SHALL rise 1 cycle after the AR handshake. Each subsequent beat SHALL be presented the cycle after an R handshake, so back-to-back beats occur with rready held high.
REQ-041 Read addresses SHALL follow the burst rules of REQ-036. rlast=1 on beat arlen. An out-of-range beat SHALL return rdata=0 and rresp=SLVERR; otherwise rresp=OKAY. rid SHALL equal the captured arid.
REQ-042 rdata, rresp, rlast and rid SHALL be stable while rvalid=1 and rready=0. R_IDLE SHALL be entered the cycle after the rlast handshake.
REQ-043 When a read and a write to the same word occur in the same cycle, the read SHALL return the pre-write value.

Reset
REQ-044 While arst=1: awready, wready, bvalid, arready, rvalid and rlast SHALL be 0; bid, bresp, rid, rdata and rresp SHALL be 0; both FSMs SHALL go to IDLE; any in-flight burst SHALL be abandoned with no response; memory contents SHALL be retained. awready and arready SHALL be 1 in the first cycle after arst falls.

Verification
REQ-045 Bench SHALL drive INCR write awaddr=0x10, awlen=3, wdata=A0..A3, wstrb=F -> bresp=OKAY, bid=awid; INCR read of the same range -> A0..A3 with rlast on beat 3.
REQ-046 Bench SHALL drive WRAP write awaddr=0x08, awlen=3 (DATA_W=32) -> words land at 0x08, 0x0C, 0x00, 0x04; FIXED read awaddr=0x04, arlen=2 -> rdata=A3 three times.
REQ-047 Bench SHALL drive a write with wstrb=4'b0101 over 0xFFFFFFFF, data 0x11223344 -> readback 0xFF22FF44.
REQ-048 Bench SHALL drive a read at word DEPTH-1 with arlen=1 -> beat 0 OKAY, beat 1 rdata=0 rresp=SLVERR; an equivalent write -> bresp=SLVERR and word 0 unchanged.
REQ-049 Bench SHALL hold rready=0 for 3 cycles mid-burst -> R outputs stable; wlast=1 on beat 1 of a 4-beat write -> burst completes 4 beats with bresp=SLVERR.
REQ-050 Bench SHALL assert arst during beat 2 of a 4-beat read -> rvalid=0 next cycle, arready=1 after release, and memory intact.
